// File: rtl/vga_pkg.sv
// Shared constants and types for the Pong VGA pipeline.
// Mode encodings, default colours and the flash FSM state type.
package vga_pkg;

    localparam int CNT_W_DEF = 11;

    localparam logic [1:0] MODE_BLACK = 2'd0;
    localparam logic [1:0] MODE_FIELD = 2'd1;
    localparam logic [1:0] MODE_BARS  = 2'd2;

    localparam logic [11:0] BG_COLOR_DEF    = 12'h000;
    localparam logic [11:0] FG_COLOR_DEF    = 12'hFFF;
    localparam logic [11:0] FLASH_COLOR_DEF = 12'hF00;

    typedef enum logic {
        FL_IDLE  = 1'b0,
        FL_FLASH = 1'b1
    } flash_state_t;

endpackage

// File: rtl/vga_flash_ctrl.sv
// Goal flash controller: counts frames from a goal pulse.
// A frame starts on each rising edge of vblnk.
module vga_flash_ctrl
    import vga_pkg::*;
#(
    parameter int FLASH_FRAMES = 16
) (
    input  logic pclk,
    input  logic rst_n,
    input  logic vblnk_in,
    input  logic goal_pulse,
    output logic flashing,
    output logic phase
);

    localparam int FW = $clog2(FLASH_FRAMES + 1);
    localparam logic [FW-1:0] RELOAD = FW'(FLASH_FRAMES);
    localparam logic [FW-1:0] ONE    = FW'(1);

    flash_state_t  state_q;
    flash_state_t  state_d;
    logic [FW-1:0] cnt_q;
    logic [FW-1:0] cnt_d;
    logic          vblnk_q;
    logic          frame_start;

    assign frame_start = vblnk_in & ~vblnk_q;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FL_IDLE;
            cnt_q   <= '0;
            vblnk_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vblnk_q <= vblnk_in;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            FL_IDLE: begin
                if (goal_pulse) begin
                    state_d = FL_FLASH;
                    cnt_d   = RELOAD;
                end
            end
            FL_FLASH: begin
                // A goal in the same cycle as a frame start reloads only.
                if (goal_pulse) begin
                    cnt_d = RELOAD;
                end else if (frame_start) begin
                    if (cnt_q <= ONE) begin
                        state_d = FL_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
            end
            default: begin
                state_d = FL_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign flashing = (state_q == FL_FLASH);
    assign phase    = cnt_q[0];

endmodule

// File: rtl/vga_playfield.sv
// Background stage: delays VGA timing by one pixel and paints
// black, the Pong playfield (with goal flash) or colour bars.
module vga_playfield
    import vga_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int COL_W        = 4,
    parameter int H_ACTIVE     = 800,
    parameter int V_ACTIVE     = 600,
    parameter int WALL_W       = 8,
    parameter int NET_W        = 4,
    parameter int NET_SEG_LOG2 = 4,
    parameter int FLASH_FRAMES = 16,
    parameter logic [3*COL_W-1:0] BG_COLOR    = BG_COLOR_DEF,
    parameter logic [3*COL_W-1:0] FG_COLOR    = FG_COLOR_DEF,
    parameter logic [3*COL_W-1:0] FLASH_COLOR = FLASH_COLOR_DEF
) (
    input  logic               pclk,
    input  logic               rst_n,
    input  logic [CNT_W-1:0]   hcount_in,
    input  logic               hsync_in,
    input  logic               hblnk_in,
    input  logic [CNT_W-1:0]   vcount_in,
    input  logic               vsync_in,
    input  logic               vblnk_in,
    input  logic [1:0]         mode,
    input  logic               goal_pulse,
    output logic [CNT_W-1:0]   hcount_out,
    output logic               hsync_out,
    output logic               hblnk_out,
    output logic [CNT_W-1:0]   vcount_out,
    output logic               vsync_out,
    output logic               vblnk_out,
    output logic [3*COL_W-1:0] rgb_out,
    output logic               flashing
);

    localparam logic [CNT_W-1:0] WALL_TOP = CNT_W'(WALL_W);
    localparam logic [CNT_W-1:0] WALL_BOT = CNT_W'(V_ACTIVE - WALL_W);
    localparam logic [CNT_W-1:0] NET_LO   = CNT_W'(H_ACTIVE/2 - NET_W/2);
    localparam logic [CNT_W-1:0] NET_HI   = CNT_W'(H_ACTIVE/2 + NET_W/2);

    logic               flash_on;
    logic               phase;
    logic               is_wall;
    logic               is_net;
    logic [2:0]         bar_idx;
    logic [3*COL_W-1:0] rgb_d;

    vga_flash_ctrl #(
        .FLASH_FRAMES (FLASH_FRAMES)
    ) u_flash (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .vblnk_in   (vblnk_in),
        .goal_pulse (goal_pulse),
        .flashing   (flash_on),
        .phase      (phase)
    );

    assign is_wall = (vcount_in < WALL_TOP) || (vcount_in >= WALL_BOT);
    assign is_net  = (hcount_in >= NET_LO) && (hcount_in < NET_HI)
                   && !vcount_in[NET_SEG_LOG2];

    // Bar index = hcount*8/H_ACTIVE, counted as crossed thresholds.
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (hcount_in >= CNT_W'((k * H_ACTIVE + 7) / 8))
                bar_idx = bar_idx + 3'd1;
        end
    end

    always_comb begin
        rgb_d = '0;
        if (hblnk_in || vblnk_in) begin
            rgb_d = '0;
        end else if (mode == MODE_BARS) begin
            rgb_d = {{COL_W{bar_idx[2]}},
                     {COL_W{bar_idx[1]}},
                     {COL_W{bar_idx[0]}}};
        end else if (mode == MODE_FIELD) begin
            if (is_wall || is_net)
                rgb_d = FG_COLOR;
            else if (flash_on && phase)
                rgb_d = FLASH_COLOR;
            else
                rgb_d = BG_COLOR;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vcount_out <= '0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
            flashing   <= 1'b0;
        end else begin
            hcount_out <= hcount_in;
            hsync_out  <= hsync_in;
            hblnk_out  <= hblnk_in;
            vcount_out <= vcount_in;
            vsync_out  <= vsync_in;
            vblnk_out  <= vblnk_in;
            rgb_out    <= rgb_d;
            flashing   <= flash_on;
        end
    end

endmodule
